// File: rtl/idma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idma_pkg
// Description : Shared types, constants and helpers for the iDMA read/write
//               burst planners.
//                 state_e        - planner FSM state encoding
//                 PAGE_BYTES     - AXI 4 KB boundary size
//                 beats_to_page  - beats left before the next 4 KB boundary
// Revision    : 1.0 - initial release
// ============================================================================
package idma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned PAGE_BYTES = 4096;

  // Number of whole beats from a beat-aligned page offset up to the next
  // 4 KB boundary. Result lies in 1..PAGE_BYTES/bytes.
  function automatic logic [12:0] beats_to_page(input logic [11:0] page_off,
                                                input int unsigned bytes);
    logic [12:0] room;
    room = 13'(PAGE_BYTES) - {1'b0, page_off};
    return room / 13'(bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/idma_outstd_cnt.sv
`default_nettype none
// ============================================================================
// Module      : idma_outstd_cnt
// Description : Outstanding-burst up/down counter with runtime limit compare.
//   aclk/aresetn  clock, asynchronous active-low reset
//   inc           burst issued this cycle
//   dec           burst completed this cycle
//   limit         runtime limit; 0 acts as 1, values above MAX clamp to MAX
//   cnt           current outstanding count
//   below_limit   count after this cycle's inc/dec is below the limit
//   underflow     dec arrived while the count was zero (count held)
// Revision    : 1.0 - initial release
// ============================================================================
module idma_outstd_cnt #(
  parameter  int unsigned MAX = 8,
  localparam int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         below_limit,
  output logic         underflow
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;
  logic [W-1:0] w_lim;
  logic         w_dec_ok;

  // A completion with nothing outstanding is reported, never counted.
  assign w_dec_ok  = dec & (r_cnt != '0);
  assign underflow = dec & (r_cnt == '0);

  always_comb begin
    w_nxt = r_cnt;
    if (inc && !w_dec_ok) begin
      w_nxt = r_cnt + W'(1);
    end else if (!inc && w_dec_ok) begin
      w_nxt = r_cnt - W'(1);
    end
  end

  always_comb begin
    w_lim = limit;
    if (limit == '0) begin
      w_lim = W'(1);
    end else if (limit > W'(MAX)) begin
      w_lim = W'(MAX);
    end
  end

  // Compare the post-update count so a new burst can be admitted in the
  // same cycle a slot frees up.
  assign below_limit = (w_nxt < w_lim);
  assign cnt         = r_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/idma_rd_burst_planner.sv
`default_nettype none
// ============================================================================
// Module      : idma_rd_burst_planner
// Description : Splits one read descriptor into AXI AR bursts bounded by
//               MAX_BURST beats and 4 KB pages, throttled by an outstanding
//               limit and downstream back-pressure; tracks returned bursts.
//   aclk/aresetn            clock, asynchronous active-low reset
//   cfg_outstd              runtime outstanding limit
//   desc_valid/ready/addr/bytes  descriptor handshake and payload
//   ar_valid/ready/addr/len      AR channel
//   bp_stall                downstream full, blocks new AR
//   rburst_done             one pulse per completed data burst
//   burst_first/burst_last  current data burst is first/last of descriptor
//   busy/done/err_unexp     status
// Revision    : 1.0 - initial release
// ============================================================================
module idma_rd_burst_planner
  import idma_pkg::*;
#(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned DATA_W     = 256,
  parameter  int unsigned LEN_W      = 32,
  parameter  int unsigned MAX_BURST  = 16,
  parameter  int unsigned OUTSTD_MAX = 8,
  localparam int unsigned OW         = $clog2(OUTSTD_MAX + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [OW-1:0]     cfg_outstd,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_bytes,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  input  logic              bp_stall,
  input  logic              rburst_done,
  output logic              burst_first,
  output logic              burst_last,
  output logic              busy,
  output logic              done,
  output logic              err_unexp
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF   = $clog2(BYTES);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_ISSUE = S_ISSUE;
  localparam logic [1:0] ST_DRAIN = S_DRAIN;
  localparam logic [1:0] ST_DONE  = S_DONE;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_rem_beats;
  logic              r_ar_valid;
  logic [ADDR_W-1:0] r_ar_addr;
  logic [7:0]        r_ar_len;
  logic              r_rcv_any;
  logic              r_err;

  logic              w_accept;
  logic              w_fire;
  logic [8:0]        w_beats_cur;
  logic [8:0]        w_beats_nxt;
  logic [ADDR_W-1:0] w_adv_addr;
  logic [LEN_W-1:0]  w_adv_rem;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [LEN_W-1:0]  w_nxt_rem;
  logic              w_can_issue;
  logic [OW-1:0]     w_cnt;
  logic              w_below;
  logic              w_underflow;
  logic              w_unused_bits;

  // min(remaining, MAX_BURST, beats to the next 4 KB boundary)
  function automatic logic [8:0] calc_beats(input logic [ADDR_W-1:0] addr,
                                            input logic [LEN_W-1:0]  rem);
    logic [12:0] cap;
    cap = beats_to_page(addr[11:0], BYTES);
    if (cap > 13'(MAX_BURST)) begin
      cap = 13'(MAX_BURST);
    end
    if (rem < LEN_W'(cap)) begin
      return rem[8:0];
    end
    return cap[8:0];
  endfunction

  assign w_unused_bits = ^{desc_addr[OFF-1:0], desc_bytes[OFF-1:0]};

  assign w_accept = desc_valid & (r_state == ST_IDLE);
  assign w_fire   = r_ar_valid & ar_ready;

  assign w_beats_cur = calc_beats(r_cur_addr, r_rem_beats);
  assign w_adv_addr  = r_cur_addr + (ADDR_W'(w_beats_cur) << OFF);
  assign w_adv_rem   = r_rem_beats - LEN_W'(w_beats_cur);

  // Cursor as it will stand after this edge; the next AR payload is derived
  // from it so a handshake can reload ar_addr/ar_len in the same edge.
  assign w_nxt_addr  = w_fire ? w_adv_addr : r_cur_addr;
  assign w_nxt_rem   = w_fire ? w_adv_rem  : r_rem_beats;
  assign w_beats_nxt = calc_beats(w_nxt_addr, w_nxt_rem);

  assign w_can_issue = (r_state == ST_ISSUE) & (w_nxt_rem != '0) &
                       ~bp_stall & w_below;

  idma_outstd_cnt #(
    .MAX (OUTSTD_MAX)
  ) u_outstd_cnt (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .inc         (w_fire),
    .dec         (rburst_done),
    .limit       (cfg_outstd),
    .cnt         (w_cnt),
    .below_limit (w_below),
    .underflow   (w_underflow)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ((desc_bytes >> OFF) == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_fire && (w_adv_rem == '0)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_cnt == '0) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cur_addr  <= '0;
      r_rem_beats <= '0;
    end else if (w_accept) begin
      r_cur_addr  <= {desc_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
      r_rem_beats <= desc_bytes >> OFF;
    end else if (w_fire) begin
      r_cur_addr  <= w_adv_addr;
      r_rem_beats <= w_adv_rem;
    end
  end

  // ar_valid and its payload only change when idle or on a handshake, so an
  // offered burst stays stable regardless of bp_stall or the limit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ar_valid <= 1'b0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
    end else if (!r_ar_valid || ar_ready) begin
      r_ar_valid <= w_can_issue;
      if (w_can_issue) begin
        r_ar_addr <= w_nxt_addr;
        r_ar_len  <= 8'(w_beats_nxt - 9'd1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rcv_any <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rcv_any <= 1'b0;
      end else if (rburst_done && (w_cnt != '0)) begin
        r_rcv_any <= 1'b1;
      end
      r_err <= w_underflow | (r_err & ~w_accept);
    end
  end

  assign desc_ready  = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign ar_valid    = r_ar_valid;
  assign ar_addr     = r_ar_addr;
  assign ar_len      = r_ar_len;
  assign err_unexp   = r_err;
  assign burst_first = busy & ~r_rcv_any & (w_cnt != '0);
  assign burst_last  = busy & (r_rem_beats == '0) & (w_cnt == OW'(1));

endmodule
`default_nettype wire
